// File: rtl/bt_status_tx_pkg.sv
// Shared definitions for the Bluetooth status transmitter.
// Holds the frame header default, frame length, the FSM state encoding
// used by the frame sequencer and the byte serialiser, the status record
// layout, the bit-period derivation and the frame byte builder.
package bt_status_tx_pkg;

  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;
  localparam int unsigned FRAME_LEN      = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    FRAME_END
  } fsm_state_t;

  // Game status as watched by the transmitter; also the snapshot layout.
  typedef struct packed {
    logic [2:0] state;
    logic [3:0] score;
    logic [3:0] miss;
    logic [1:0] life;
  } status_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Byte idx of a status frame; index 4 is the XOR check of bytes 1..3.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input status_t    s,
                                            input logic [7:0] header);
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    b1 = {5'b0, s.state};
    b2 = {s.miss, s.score};
    b3 = {6'b0, s.life};
    case (idx)
      3'd0:    return header;
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      default: return b1 ^ b2 ^ b3;
    endcase
  endfunction

endpackage

// File: rtl/bt_status_tx_uart_tx_byte.sv
// Single-byte UART 8N1 serialiser.
// Ports:
//   clk, rst (async, active-low)
//   start      : load data and begin the start bit at this edge
//   data[7:0]  : byte to send, sampled when start is accepted
//   tx         : serial line, idles high
//   busy       : high from the start bit through the stop bit
//   done       : high during the last cycle of the stop bit
// A start accepted during that last stop cycle chains the next byte with
// no idle gap on the line.
module uart_tx_byte
  import bt_status_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  fsm_state_t  st;
  logic [TW-1:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;

  assign bit_end = (timer == T_LAST);
  // Decoded strobe so the sequencer can hand over the next byte on the
  // same edge the stop bit ends.
  assign done    = (st == STOP) && bit_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            shreg <= data;
            tx    <= 1'b0;
            busy  <= 1'b1;
            timer <= '0;
            st    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            st      <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
              st <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (start) begin
              shreg <= data;
              tx    <= 1'b0;
              st    <= START;
            end else begin
              busy <= 1'b0;
              st   <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bt_status_tx.sv
// Bluetooth status return-path transmitter.
// Sends the 5-byte frame {HEADER, state, {miss,score}, life, xor} over
// UART 8N1 whenever the watched status differs from the last sent
// snapshot or send_req pulses. Changes arriving mid-frame coalesce into
// a single follow-up frame sent straight after FRAME_END.
// Ports:
//   clk, rst (async, active-low)
//   state[2:0], score[3:0], miss[3:0], life[1:0] : watched status
//   send_req   : one-cycle request for a frame regardless of change
//   tx         : serial line to the Bluetooth module RX, idles high
//   tx_busy    : high while a frame is on the line
//   frame_done : one-cycle pulse after the last stop bit
module bt_status_tx
  import bt_status_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter logic [7:0]  HEADER   = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [3:0] score,
  input  logic [3:0] miss,
  input  logic [1:0] life,
  input  logic       send_req,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0]  LAST_IDX     = 3'(FRAME_LEN - 1);

  status_t    cur;
  status_t    snap;
  status_t    frame_buf;
  fsm_state_t fsm;
  logic [2:0] byte_idx;
  logic       pending;
  logic       trig;

  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_busy;
  logic       byte_done;

  assign cur  = {state, score, miss, life};
  assign trig = send_req | (cur != snap);

  // The sequencer uses IDLE, START (frame on the line) and FRAME_END.
  // Byte 0 is always the header, so a new frame can start the same edge
  // its snapshot is latched; later bytes come from the frozen buffer.
  always_comb begin
    byte_start = 1'b0;
    byte_data  = HEADER;
    case (fsm)
      IDLE:      byte_start = trig & ~byte_busy;
      START: begin
        byte_start = byte_done && (byte_idx != LAST_IDX);
        byte_data  = frame_byte(byte_idx + 3'd1, frame_buf, HEADER);
      end
      FRAME_END: byte_start = (pending | trig) & ~byte_busy;
      default:   byte_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= IDLE;
      snap       <= '0;
      frame_buf  <= '0;
      byte_idx   <= '0;
      pending    <= 1'b0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (byte_start) begin
            snap      <= cur;
            frame_buf <= cur;
            byte_idx  <= '0;
            tx_busy   <= 1'b1;
            fsm       <= START;
          end
        end
        START: begin
          // Snapshot stays at the frame contents so every change seen
          // while busy still differs at FRAME_END.
          if (trig) pending <= 1'b1;
          if (byte_done) begin
            if (byte_idx == LAST_IDX) begin
              tx_busy    <= 1'b0;
              frame_done <= 1'b1;
              fsm        <= FRAME_END;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        FRAME_END: begin
          if (byte_start) begin
            pending   <= 1'b0;
            snap      <= cur;
            frame_buf <= cur;
            byte_idx  <= '0;
            tx_busy   <= 1'b1;
            fsm       <= START;
          end else begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .busy (byte_busy),
    .done (byte_done)
  );

endmodule

// File: tb/tb_bt_status_tx.sv
// Directed bench for bt_status_tx at 16 clocks per bit. Frames are
// decoded by sampling tx at mid-bit on the falling clock edge.
module tb_bt_status_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic [3:0] score;
  logic [3:0] miss;
  logic [1:0] life;
  logic       send_req;
  logic       tx;
  logic       tx_busy;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  int done_cnt = 0;
  int busy_run = 0;
  int last_run = 0;

  int d0;
  int act;

  always #5 clk = ~clk;

  bt_status_tx #(
    .CLK_FREQ(16),
    .BAUD    (1),
    .HEADER  (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .score     (score),
    .miss      (miss),
    .life      (life),
    .send_req  (send_req),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .frame_done(frame_done)
  );

  // Length of the most recent tx_busy run and total frame_done pulses.
  always @(negedge clk) begin
    if (tx_busy === 1'b1) begin
      busy_run = busy_run + 1;
    end else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (frame_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the first negedge of the start bit of byte 0. Returns at
  // the middle of the last stop bit (cycle 792 of the frame).
  task automatic decode(input string tag, input logic [39:0] exp);
    logic [7:0] b;
    logic       s0;
    logic       s1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      s0 = tx;
      b  = '0;
      for (int j = 0; j < 8; j++) begin
        repeat (16) @(negedge clk);
        b[j] = tx;
      end
      repeat (16) @(negedge clk);
      s1 = tx;
      check($sformatf("%s_byte%0d", tag, i), {22'b0, s0, b, s1},
            {22'b0, 1'b0, exp[39-8*i -: 8], 1'b1});
      if (i < 4) repeat (16) @(negedge clk);
    end
  endtask

  // Counts cycles with any line activity over n idle cycles.
  task automatic quiet(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) cnt++;
    end
  endtask

  task automatic pulse_req();
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    state    = '0;
    score    = '0;
    miss     = '0;
    life     = '0;
    send_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx),         32'd1);
    check("rst_busy", 32'(tx_busy),    32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b1;

    // 1: quiet line with all-zero inputs
    d0 = done_cnt;
    quiet(2000, act);
    check("idle_activity", 32'(act), 32'd0);
    check("idle_done", 32'(done_cnt - d0), 32'd0);

    // 2: single state change
    d0 = done_cnt;
    state = 3'b001;
    @(negedge clk);
    check("t2_latency_tx", 32'(tx),      32'd0);
    check("t2_busy_set",   32'(tx_busy), 32'd1);
    decode("t2", 40'hA5_01_00_00_01);
    repeat (8) @(negedge clk);
    check("t2_done",   32'(frame_done), 32'd1);
    check("t2_end_tx", 32'(tx),         32'd1);
    quiet(100, act);
    check("t2_no_repeat", 32'(act), 32'd0);
    check("t2_busy_len", 32'(last_run), 32'd800);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3: four inputs change together
    d0 = done_cnt;
    state = 3'b010;
    score = 4'd3;
    miss  = 4'd2;
    life  = 2'd3;
    @(negedge clk);
    check("t3_start", 32'(tx), 32'd0);
    decode("t3", 40'hA5_02_23_03_22);
    repeat (8) @(negedge clk);
    check("t3_done", 32'(frame_done), 32'd1);
    quiet(100, act);
    check("t3_no_repeat", 32'(act), 32'd0);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 4: score changes during byte 2, follow-up frame back to back
    d0 = done_cnt;
    pulse_req();
    check("t4_start", 32'(tx), 32'd0);
    fork
      decode("t4a", 40'hA5_02_23_03_22);
      begin
        repeat (340) @(negedge clk);
        score = 4'd4;
      end
    join
    repeat (8) @(negedge clk);
    check("t4a_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("t4_back_to_back", 32'(tx), 32'd0);
    decode("t4b", 40'hA5_02_24_03_25);
    repeat (8) @(negedge clk);
    check("t4b_done", 32'(frame_done), 32'd1);
    quiet(100, act);
    check("t4_no_repeat", 32'(act), 32'd0);
    check("t4_busy_len", 32'(last_run), 32'd800);
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd2);

    // 5: send_req while idle, then two requests while busy
    d0 = done_cnt;
    pulse_req();
    check("t5_start", 32'(tx), 32'd0);
    fork
      decode("t5a", 40'hA5_02_24_03_25);
      begin
        repeat (100) @(negedge clk);
        pulse_req();
        repeat (200) @(negedge clk);
        pulse_req();
      end
    join
    repeat (8) @(negedge clk);
    check("t5a_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("t5_follow_up", 32'(tx), 32'd0);
    decode("t5b", 40'hA5_02_24_03_25);
    repeat (8) @(negedge clk);
    check("t5b_done", 32'(frame_done), 32'd1);
    quiet(200, act);
    check("t5_no_third", 32'(act), 32'd0);
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd2);

    // 6: asynchronous reset mid data bit of byte 1
    d0 = done_cnt;
    state = 3'b001;
    @(negedge clk);
    check("t6_start", 32'(tx), 32'd0);
    repeat (213) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_tx",   32'(tx),         32'd1);
    check("t6_rst_busy", 32'(tx_busy),    32'd0);
    check("t6_rst_done", 32'(frame_done), 32'd0);
    state = 3'b001;
    score = '0;
    miss  = '0;
    life  = '0;
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_restart", 32'(tx), 32'd0);
    decode("t6", 40'hA5_01_00_00_01);
    repeat (8) @(negedge clk);
    check("t6_done", 32'(frame_done), 32'd1);
    quiet(100, act);
    check("t6_no_repeat", 32'(act), 32'd0);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
